// File: rtl/ir_nec_decoder_if.sv
// ir_nec_decoder_if
//   Groups the decoder's receiver input and decoded-code outputs.
//   master : decoder side (samples ir_in, drives the code/pulse outputs)
//   slave  : consumer side (drives ir_in, observes the decoder outputs)
// Signals:
//   ir_in                 raw receiver output, idle high, mark = low, asynchronous
//   decoded_ir_out[31:0]  last good code, held between frames
//   decoded_ir_out_valid  one-cycle pulse when decoded_ir_out was updated
//   repeat_out            one-cycle pulse on a valid repeat frame
//   error_out             one-cycle pulse on a timing (or checksum) failure
//   busy_out              high while a frame is being received
interface ir_nec_decoder_if;
    logic        ir_in;
    logic [31:0] decoded_ir_out;
    logic        decoded_ir_out_valid;
    logic        repeat_out;
    logic        error_out;
    logic        busy_out;

    modport master (
        input  ir_in,
        output decoded_ir_out,
        output decoded_ir_out_valid,
        output repeat_out,
        output error_out,
        output busy_out
    );

    modport slave (
        output ir_in,
        input  decoded_ir_out,
        input  decoded_ir_out_valid,
        input  repeat_out,
        input  error_out,
        input  busy_out
    );
endinterface

// File: rtl/ir_nec_decoder.sv
// ir_nec_decoder
//   Turns the demodulated IR receiver output into 32-bit NEC codes. Mark and space
//   lengths are measured in half-unit ticks and checked against fixed windows; a
//   frame with bad timing produces an error pulse instead of a code.
// Ports:
//   clk_pixel_in  pixel clock, the only clock
//   rst_in        asynchronous active-low reset
//   ir            ir_nec_decoder_if.master (ir_in in; code, valid, repeat, error, busy out)
// Parameters:
//   HALF_UNIT_CYCLES    clk_pixel_in cycles per half unit
//   TIMEOUT_HALF_UNITS  half units after which any mark or space aborts the frame
// Build option:
//   IR_CHECKSUM_EN  when defined, a completed data frame must carry inverted
//                   address/command bytes; otherwise any 32-bit pattern is accepted.
module ir_nec_decoder #(
    parameter int unsigned HALF_UNIT_CYCLES   = 20883,
    parameter int unsigned TIMEOUT_HALF_UNITS = 40
) (
    input  logic             clk_pixel_in,
    input  logic             rst_in,
    ir_nec_decoder_if.master ir
);

    localparam int unsigned CntW = (HALF_UNIT_CYCLES > 1) ? $clog2(HALF_UNIT_CYCLES) : 1;

    localparam logic [2:0] StIdle      = 3'd0;
    localparam logic [2:0] StLeadMark  = 3'd1;
    localparam logic [2:0] StLeadSpace = 3'd2;
    localparam logic [2:0] StBitMark   = 3'd3;
    localparam logic [2:0] StBitSpace  = 3'd4;
    localparam logic [2:0] StStopMark  = 3'd5;

    // ---------------- input conditioning ----------------
    logic sync1_q, sync2_q, prev_q;
    logic fall_q, rise_q;

    // Edge pulses are registered, so every edge reaches the FSM with the same
    // fixed delay and measured lengths stay exact.
    always_ff @(posedge clk_pixel_in or negedge rst_in) begin
        if (!rst_in) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            fall_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= ir.ir_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            fall_q  <= prev_q & ~sync2_q;
            rise_q  <= ~prev_q & sync2_q;
        end
    end

    logic edge_seen;
    assign edge_seen = fall_q | rise_q;

    // ---------------- prescaler and half-unit counter ----------------
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [5:0]      hu_q, hu_d, hu_eff;
    logic            tick;

    assign tick = (cnt_q == CntW'(HALF_UNIT_CYCLES - 1));
    // Length including a tick landing this cycle, so a period of N half units
    // measures exactly N at the edge that ends it.
    assign hu_eff = (tick && (hu_q != 6'd63)) ? hu_q + 6'd1 : hu_q;

    always_comb begin
        cnt_d = cnt_q;
        hu_d  = hu_eff;
        if (edge_seen) begin
            cnt_d = '0;
            hu_d  = 6'd0;
        end else if (tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    function automatic logic in_win(input logic [5:0] v, input logic [5:0] lo,
                                    input logic [5:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // ---------------- frame FSM ----------------
    logic [2:0]  state_q, state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [31:0] shreg_q, shreg_d;
    logic        rpt_q, rpt_d;
    logic [31:0] code_q, code_d;
    logic        valid_q, valid_d;
    logic        repeat_q, repeat_d;
    logic        error_q, error_d;
    logic        bad;
    logic        cksum_ok;

`ifdef IR_CHECKSUM_EN
    assign cksum_ok = (shreg_q[23:16] == ~shreg_q[31:24]) && (shreg_q[7:0] == ~shreg_q[15:8]);
`else
    assign cksum_ok = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        rpt_d     = rpt_q;
        code_d    = code_q;
        valid_d   = 1'b0;
        repeat_d  = 1'b0;
        error_d   = 1'b0;
        bad       = 1'b0;

        case (state_q)
            StIdle: begin
                if (fall_q) begin
                    state_d = StLeadMark;
                    rpt_d   = 1'b0;
                end
            end
            StLeadMark: begin
                if (rise_q) begin
                    if (in_win(hu_eff, 6'd28, 6'd36)) state_d = StLeadSpace;
                    else                              bad     = 1'b1;
                end
            end
            StLeadSpace: begin
                if (fall_q) begin
                    if (in_win(hu_eff, 6'd14, 6'd18)) begin
                        state_d   = StBitMark;
                        bit_cnt_d = 5'd0;
                        shreg_d   = 32'h0;
                    end else if (in_win(hu_eff, 6'd6, 6'd10)) begin
                        state_d = StStopMark;
                        rpt_d   = 1'b1;
                    end else begin
                        bad = 1'b1;
                    end
                end
            end
            StBitMark: begin
                if (rise_q) begin
                    if (in_win(hu_eff, 6'd1, 6'd3)) state_d = StBitSpace;
                    else                            bad     = 1'b1;
                end
            end
            StBitSpace: begin
                if (fall_q) begin
                    if (in_win(hu_eff, 6'd1, 6'd3) || in_win(hu_eff, 6'd5, 6'd7)) begin
                        // First received bit ends up in bit 31.
                        shreg_d   = {shreg_q[30:0], in_win(hu_eff, 6'd5, 6'd7)};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        state_d   = (bit_cnt_q == 5'd31) ? StStopMark : StBitMark;
                    end else begin
                        bad = 1'b1;
                    end
                end
            end
            StStopMark: begin
                if (rise_q) begin
                    if (!in_win(hu_eff, 6'd1, 6'd3)) begin
                        bad = 1'b1;
                    end else if (rpt_q) begin
                        repeat_d = 1'b1;
                        state_d  = StIdle;
                    end else if (!cksum_ok) begin
                        bad = 1'b1;
                    end else begin
                        code_d  = shreg_q;
                        valid_d = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // An edge in the same cycle wins over the timeout.
        if ((state_q != StIdle) && !edge_seen && (hu_q >= 6'(TIMEOUT_HALF_UNITS))) begin
            bad = 1'b1;
        end

        if (bad) begin
            error_d   = 1'b1;
            valid_d   = 1'b0;
            repeat_d  = 1'b0;
            code_d    = code_q;
            shreg_d   = 32'h0;
            rpt_d     = 1'b0;
            // A failing fall may be the lead mark of a fresh frame.
            state_d   = fall_q ? StLeadMark : StIdle;
        end
    end

    always_ff @(posedge clk_pixel_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt_q     <= '0;
            hu_q      <= 6'd0;
            state_q   <= StIdle;
            bit_cnt_q <= 5'd0;
            shreg_q   <= 32'h0;
            rpt_q     <= 1'b0;
            code_q    <= 32'h0;
            valid_q   <= 1'b0;
            repeat_q  <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            hu_q      <= hu_d;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            rpt_q     <= rpt_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            repeat_q  <= repeat_d;
            error_q   <= error_d;
        end
    end

    assign ir.decoded_ir_out       = code_q;
    assign ir.decoded_ir_out_valid = valid_q;
    assign ir.repeat_out           = repeat_q;
    assign ir.error_out            = error_q;
    assign ir.busy_out             = (state_q != StIdle);

endmodule

// File: tb/tb_ir_nec_decoder.sv
// tb_ir_nec_decoder
//   Directed bench for ir_nec_decoder with HALF_UNIT_CYCLES = 4 (one half unit is
//   four clocks) and TIMEOUT_HALF_UNITS = 40. Inputs change on the falling clock
//   edge; outputs are sampled 1 time unit after the rising edge. When built with
//   IR_CHECKSUM_EN the expectations follow the checksum rule.
module tb_ir_nec_decoder;

    localparam int unsigned HU = 4;

    logic clk_pixel_in = 1'b0;
    logic rst_in       = 1'b0;

    ir_nec_decoder_if ir_bus ();

    ir_nec_decoder #(
        .HALF_UNIT_CYCLES  (4),
        .TIMEOUT_HALF_UNITS(40)
    ) dut (
        .clk_pixel_in(clk_pixel_in),
        .rst_in      (rst_in),
        .ir          (ir_bus)
    );

    always #5 clk_pixel_in = ~clk_pixel_in;

    int checks = 0;
    int errors = 0;

    // Running pulse totals; scenarios compare differences.
    int n_valid  = 0;
    int n_repeat = 0;
    int n_error  = 0;
    int n_multi  = 0;

    always @(posedge clk_pixel_in) begin
        if (ir_bus.decoded_ir_out_valid) n_valid++;
        if (ir_bus.repeat_out) n_repeat++;
        if (ir_bus.error_out) n_error++;
        if ((int'(ir_bus.decoded_ir_out_valid) + int'(ir_bus.repeat_out) +
             int'(ir_bus.error_out)) > 1) n_multi++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic chk_ok(input logic [31:0] c);
`ifdef IR_CHECKSUM_EN
        return (c[23:16] == ~c[31:24]) && (c[7:0] == ~c[15:8]);
`else
        return 1'b1;
`endif
    endfunction

    logic [31:0] exp_code = 32'h0;

    task automatic level_cyc(input logic v, input int cycles);
        ir_bus.ir_in = v;
        repeat (cycles) @(negedge clk_pixel_in);
    endtask

    task automatic send_bit(input logic b);
        level_cyc(1'b0, 2 * HU);
        level_cyc(1'b1, (b ? 6 : 2) * HU);
    endtask

    // Remaining lead mark, lead space, 32 bits MSB first, stop mark, line released.
    task automatic send_frame_tail(input logic [31:0] code, input int lead_left);
        level_cyc(1'b0, lead_left);
        level_cyc(1'b1, 16 * HU);
        for (int i = 31; i >= 0; i--) send_bit(code[i]);
        level_cyc(1'b0, 2 * HU);
        ir_bus.ir_in = 1'b1;
    endtask

    // Checks after the final rise: pulse on the 4th rising edge, totals, held code.
    task automatic finish_frame(input string tag, input logic [31:0] code, input int v0,
                                input int e0, input int r0, input int extra_err);
        logic ok;
        ok = chk_ok(code);
        repeat (3) @(posedge clk_pixel_in);
        #1 check({tag, "_valid_edge3"}, 32'(ir_bus.decoded_ir_out_valid), 32'd0);
        @(posedge clk_pixel_in);
        #1 check({tag, "_valid_edge4"}, 32'(ir_bus.decoded_ir_out_valid), 32'(ok));
        if (ok) exp_code = code;
        repeat (10) @(negedge clk_pixel_in);
        check({tag, "_nvalid"}, 32'(n_valid - v0), 32'(ok));
        check({tag, "_nerror"}, 32'(n_error - e0), 32'(extra_err + (ok ? 0 : 1)));
        check({tag, "_nrepeat"}, 32'(n_repeat - r0), 32'd0);
        check({tag, "_code"}, ir_bus.decoded_ir_out, exp_code);
        check({tag, "_busy"}, 32'(ir_bus.busy_out), 32'd0);
    endtask

    task automatic run_frame(input string tag, input logic [31:0] code);
        int v0, e0, r0;
        v0 = n_valid; e0 = n_error; r0 = n_repeat;
        send_frame_tail(code, 32 * HU);
        finish_frame(tag, code, v0, e0, r0, 0);
    endtask

    initial begin
        int v0, e0, r0, cyc;
        logic [31:0] bad_code;
        ir_bus.ir_in = 1'b1;

        // Reset and idle line
        repeat (5) @(negedge clk_pixel_in);
        check("rst_code", ir_bus.decoded_ir_out, 32'h0);
        check("rst_busy", 32'(ir_bus.busy_out), 32'd0);
        rst_in = 1'b1;
        repeat (20) @(negedge clk_pixel_in);
        check("idle_code", ir_bus.decoded_ir_out, 32'h0);
        check("idle_valid", 32'(ir_bus.decoded_ir_out_valid), 32'd0);
        check("idle_repeat", 32'(ir_bus.repeat_out), 32'd0);
        check("idle_error", 32'(ir_bus.error_out), 32'd0);
        check("idle_busy", 32'(ir_bus.busy_out), 32'd0);

        // Clean frames
        run_frame("deadbeef", 32'hDEADBEEF);
        run_frame("00ff10ef", 32'h00FF10EF);
        run_frame("20facade", 32'h20FACADE);

        // Repeat frame: lead 32, space 8, stop 2
        v0 = n_valid; e0 = n_error; r0 = n_repeat;
        level_cyc(1'b0, 32 * HU);
        level_cyc(1'b1, 8 * HU);
        level_cyc(1'b0, 2 * HU);
        ir_bus.ir_in = 1'b1;
        repeat (4) @(posedge clk_pixel_in);
        #1 check("rpt_edge4", 32'(ir_bus.repeat_out), 32'd1);
        repeat (10) @(negedge clk_pixel_in);
        check("rpt_nrepeat", 32'(n_repeat - r0), 32'd1);
        check("rpt_nvalid", 32'(n_valid - v0), 32'd0);
        check("rpt_nerror", 32'(n_error - e0), 32'd0);
        check("rpt_code", ir_bus.decoded_ir_out, exp_code);

        // Bit 5 with a 4-half-unit space; its closing fall starts the next frame
        bad_code = 32'h20FACADE;
        v0 = n_valid; e0 = n_error; r0 = n_repeat;
        level_cyc(1'b0, 32 * HU);
        level_cyc(1'b1, 16 * HU);
        for (int i = 31; i > 26; i--) send_bit(bad_code[i]);
        level_cyc(1'b0, 2 * HU);
        level_cyc(1'b1, 4 * HU);
        level_cyc(1'b0, 8);
        check("badbit_nerror", 32'(n_error - e0), 32'd1);
        check("badbit_busy", 32'(ir_bus.busy_out), 32'd1);
        send_frame_tail(32'h20FACADE, 32 * HU - 8);
        finish_frame("after_bad", 32'h20FACADE, v0, e0, r0, 1);

        // Line held low for 50 half units: timeout when hu reaches 40
        v0 = n_valid; e0 = n_error;
        ir_bus.ir_in = 1'b0;
        cyc = 0;
        while (cyc < 400) begin
            @(posedge clk_pixel_in);
            #1 cyc++;
            if (ir_bus.error_out) break;
        end
        check("tmo_cycle", 32'(cyc), 32'd165);
        repeat (200 - cyc) @(negedge clk_pixel_in);
        check("tmo_busy", 32'(ir_bus.busy_out), 32'd0);
        check("tmo_nerror", 32'(n_error - e0), 32'd1);
        check("tmo_nvalid", 32'(n_valid - v0), 32'd0);
        level_cyc(1'b1, 20);
        check("tmo_rise_busy", 32'(ir_bus.busy_out), 32'd0);
        check("tmo_rise_nerror", 32'(n_error - e0), 32'd1);

        // Reset asserted during the mark of bit 16
        v0 = n_valid; e0 = n_error; r0 = n_repeat;
        level_cyc(1'b0, 32 * HU);
        level_cyc(1'b1, 16 * HU);
        for (int i = 31; i > 15; i--) send_bit(bad_code[i]);
        level_cyc(1'b0, 4);
        #2 rst_in = 1'b0;
        #1;
        check("midrst_code", ir_bus.decoded_ir_out, 32'h0);
        check("midrst_busy", 32'(ir_bus.busy_out), 32'd0);
        check("midrst_error", 32'(ir_bus.error_out), 32'd0);
        exp_code = 32'h0;
        @(negedge clk_pixel_in);
        level_cyc(1'b1, 5);
        rst_in = 1'b1;
        repeat (10) @(negedge clk_pixel_in);
        check("midrst_pulses", 32'((n_valid - v0) + (n_error - e0) + (n_repeat - r0)), 32'd0);
        run_frame("post_rst", 32'h00FF10EF);

        check("pulse_exclusive", 32'(n_multi), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ir_nec_decoder.md
Name: ir_nec_decoder

Overview:
- Upstream stage of the attack logic: turns the raw, demodulated IR receiver output into 32-bit codes with a one-cycle valid pulse.
- Its outputs drive the attack logic's decoded-IR inputs, so the values it produces are compared against BLOCK_CODE and LUNGE_CODE.
- Measures mark and space lengths of a NEC-style frame in half-unit ticks and classifies each one.
- Frames with bad timing raise an error pulse instead of a code.

Parameters:
- HALF_UNIT_CYCLES, 20883: clk_pixel_in cycles per half unit (281.25 us at 74.25 MHz).
- TIMEOUT_HALF_UNITS, 40: half units after which any mark or space aborts the frame.

Ports:
- clk_pixel_in  input  1  pixel clock; the only clock.
- rst_in  input  1  reset, asynchronous, active-low.
- ir_in  input  1  raw receiver output; idle high, mark = low; asynchronous to clk_pixel_in.
- decoded_ir_out  output  32  last good code; holds its value between frames.
- decoded_ir_out_valid  output  1  one-cycle pulse when decoded_ir_out has been updated.
- repeat_out  output  1  one-cycle pulse on a valid repeat frame.
- error_out  output  1  one-cycle pulse on a timing or checksum failure.
- busy_out  output  1  high whenever state != IDLE.

Behaviour:
- Reset (rst_in low): asynchronous clear of all outputs, counters and the shift register; synchronizer flops set to 1; state = IDLE.
- Input conditioning: ir_in passes through 2 synchronizer flops and one more flop for edge detection.
  - fall = previous sample 1, current sample 0; rise = the opposite.
- Prescaler:
  - Counts 0..HALF_UNIT_CYCLES-1 and pulses a tick on wrap.
  - The tick drives a 6-bit half-unit counter hu that saturates at 63.
  - Both counters clear on every fall or rise.
- Length windows, with hu sampled at the edge that ends the period:
  - Lead mark: 28..36.
  - Lead space, data frame: 14..18.
  - Lead space, repeat frame: 6..10.
  - Bit mark and stop mark: 1..3.
  - Bit space 0: 1..3.
  - Bit space 1: 5..7.
- States:
  - IDLE: fall -> LEAD_MARK.
  - LEAD_MARK: rise with hu in window -> LEAD_SPACE.
  - LEAD_SPACE: fall with data window -> BIT_MARK and bit count = 0; fall with repeat window -> STOP_MARK and repeat flag set.
  - BIT_MARK: rise with hu in window -> BIT_SPACE.
  - BIT_SPACE: on fall, shift the classified bit into shreg[0] (shreg << 1), so the first received bit ends in bit 31. After the 32nd bit -> STOP_MARK; otherwise -> BIT_MARK.
  - STOP_MARK: rise with hu in window. Repeat flag set -> repeat_out pulse. Otherwise -> decoded_ir_out <= shreg with a valid pulse. Either way -> IDLE.
- Latency: decoded_ir_out_valid rises on the 4th clk_pixel_in edge after ir_in rises (2 synchronizer flops + edge flop + output register).
- Error handling:
  - Trigger: an out-of-window length, or hu reaching TIMEOUT_HALF_UNITS in any state other than IDLE.
  - error_out pulses for one cycle and shreg is discarded.
  - If the error came from a fall: next state = LEAD_MARK with counters cleared, because that fall may start a new frame.
  - Otherwise: next state = IDLE.
  - decoded_ir_out is unchanged.
- Simultaneous events: an edge has priority over the timeout in the same cycle. The valid, repeat and error pulses are mutually exclusive.
- A rise while in IDLE is ignored. A held-low line in IDLE does not retrigger.
- Reset in mid-frame returns to IDLE immediately; no pulses are generated.

Optional Feature:
- Macro: IR_CHECKSUM_EN.
- Defined:
  - At STOP_MARK completion, require shreg[23:16] == ~shreg[31:24] and shreg[7:0] == ~shreg[15:8].
  - On failure: error_out pulses, no valid pulse, decoded_ir_out is kept.
  - Repeat frames are not checked.
- Undefined: any 32-bit pattern is accepted, which is required for codes such as 32'hDEADBEEF.

Test Plan:
Run all scenarios with HALF_UNIT_CYCLES=4 and TIMEOUT_HALF_UNITS=40.
- Idle line after reset -> all outputs 0, busy_out 0, decoded_ir_out 32'h0.
- Clean frame: lead 32/16 half units, 32 bits of 32'hDEADBEEF with '1' space 6 and '0' space 2, stop mark 2 -> a single decoded_ir_out_valid pulse 4 cycles after the final rise; decoded_ir_out = 32'hDEADBEEF (macro undefined).
- Repeat frame: lead mark 32, space 8, stop mark 2, sent after the 32'h20FACADE frame -> repeat_out pulses once; no valid pulse; decoded_ir_out stays 32'h20FACADE.
- Bit 5 has bit space 4 -> error_out pulses once and the FSM moves to LEAD_MARK. A following clean frame of 32'h20FACADE then decodes correctly.
- Line held low for 50 half units after the lead mark starts -> error_out pulses when hu = 40, state = IDLE, busy_out 0, no valid pulse.
- With IR_CHECKSUM_EN defined: 32'h00FF10EF -> valid pulse; 32'hDEADBEEF -> error_out pulse and decoded_ir_out unchanged.
- Reset asserted at bit 16 -> outputs clear asynchronously; the next full frame decodes normally.
